// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with a 2-entry output buffer.
//
// Drives a synchronous instruction ROM with a word-aligned address. The ROM
// answers one cycle later, and the answer lands in a 2-entry FIFO that feeds
// decode through a valid/ready handshake. A new fetch is issued only when the
// FIFO is sure to have room for it. A redirect discards everything buffered
// or in flight and restarts fetching at the new target.
//
// Parameters
//   RESET_PC             PC of the first fetch after reset.
// Ports
//   clk                  single clock, all state updates on its rising edge
//   rst                  synchronous, active-low reset
//   imem_addr   [31:0]   byte address to the instruction ROM (bits [1:0] = 0)
//   imem_inst   [31:0]   ROM data for the address presented the cycle before
//   redirect_valid       branch/jump redirect request
//   redirect_pc [31:0]   redirect target (bits [1:0] ignored)
//   out_valid            an instruction is presented to decode
//   out_ready            decode accepts the presented instruction
//   out_pc      [31:0]   PC of the presented instruction
//   out_inst    [31:0]   presented instruction word
//   perf_fetch_count     accepted-transfer counter
//   perf_redirect_count  redirect-cycle counter
//
// Configuration
//   FETCH_PERF_EN        when defined, the two perf counters are implemented;
//                        otherwise both perf ports are tied to zero.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_redirect_count
);

  logic [31:0] fetch_pc;
  logic        inflight;
  logic [31:0] inflight_pc;

  logic        head;
  logic [1:0]  buf_count;
  logic [31:0] buf_pc   [2];
  logic [31:0] buf_inst [2];

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic        wr_idx;

  // The low address bits of a redirect target are dropped by design.
  logic        unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign imem_addr = fetch_pc;
  assign out_valid = (buf_count != 2'd0);
  assign pop       = out_valid & out_ready;
  // ROM data is only meaningful the cycle after an issue.
  assign push      = inflight;
  // A push never finds the buffer full, so the tail slot is head + count.
  assign wr_idx    = head ^ buf_count[0];

  // NOTE: always_comb gives every output a value on every path before any
  // conditional logic, so no latch can be inferred.
  always_comb begin
    occupancy = 3'd0;
    issue     = 1'b0;
    // Entries that will hold data next cycle, counting the one in flight.
    occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    issue     = rst & ~redirect_valid & (occupancy < 3'd2);
  end

  // Idle outputs read as zero so stale buffer contents never leak out.
  assign out_pc   = out_valid ? buf_pc[head]   : 32'h0000_0000;
  assign out_inst = out_valid ? buf_inst[head] : 32'h0000_0000;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= {RESET_PC[31:2], 2'b00};
      inflight    <= 1'b0;
      inflight_pc <= 32'h0000_0000;
      head        <= 1'b0;
      buf_count   <= 2'd0;
    end else if (redirect_valid) begin
      // Flush: buffered entries and the in-flight fetch are abandoned.
      fetch_pc  <= {redirect_pc[31:2], 2'b00};
      inflight  <= 1'b0;
      head      <= 1'b0;
      buf_count <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  // NOTE: the buffer storage has no reset; buf_count alone decides which
  // entries are live, and the output mux hides the rest.
  always_ff @(posedge clk) begin
    if (rst && !redirect_valid && push) begin
      buf_pc[wr_idx]   <= inflight_pc;
      buf_inst[wr_idx] <= imem_inst;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_count    <= 32'h0000_0000;
      redirect_count <= 32'h0000_0000;
    end else begin
      // A transfer in a redirect cycle still counts; it completed.
      if (pop) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect_valid) begin
        redirect_count <= redirect_count + 32'd1;
      end
    end
  end

  assign perf_fetch_count    = fetch_count;
  assign perf_redirect_count = redirect_count;
`else
  assign perf_fetch_count    = 32'h0000_0000;
  assign perf_redirect_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
//
// A behavioural ROM returns rom_word(addr) one cycle after the address is
// presented. Inputs change 1 ns after each rising edge; outputs are checked
// at that same point, so every check sees settled post-edge state.
// Expected perf counts follow FETCH_PERF_EN as defined for this build.

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst = 32'h0000_0000;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] perf_fetch_count;
  logic [31:0] perf_redirect_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .imem_addr           (imem_addr),
    .imem_inst           (imem_inst),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_pc              (out_pc),
    .out_inst            (out_inst),
    .perf_fetch_count    (perf_fetch_count),
    .perf_redirect_count (perf_redirect_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Synchronous ROM: one cycle of read latency.
  always @(posedge clk) imem_inst <= rom_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Checks the presented instruction and the current fetch address.
  task automatic check_stream(input string tag, input logic [31:0] pc,
                              input logic [31:0] addr);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".pc"},    out_pc,    pc);
    check({tag, ".inst"},  out_inst,  rom_word(pc));
    check({tag, ".addr"},  imem_addr, addr);
  endtask

  task automatic check_empty(input string tag, input logic [31:0] addr);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".addr"},  imem_addr, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_fetch;
    logic [31:0] exp_redir;
`ifdef FETCH_PERF_EN
    exp_fetch = 32'd10;
    exp_redir = 32'd3;
`else
    exp_fetch = 32'd0;
    exp_redir = 32'd0;
`endif

    // Held in reset: no issue, everything cleared.
    rst            = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    tick();
    tick();
    check_empty("reset", 32'h0000_0000);
    check("reset.pc",    out_pc,   32'h0);
    check("reset.inst",  out_inst, 32'h0);
    check("reset.pfc",   perf_fetch_count,    32'h0);
    check("reset.prc",   perf_redirect_count, 32'h0);

    // Release: first fetch at 0, first output two cycles later, no bubbles.
    rst = 1'b1;
    tick();
    check_empty("start1", 32'h0000_0004);
    tick();
    check_stream("start2", 32'h0000_0000, 32'h0000_0008);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_stream("stream", 32'(4 * i), 32'(4 * i + 8));
    end

    // Back-pressure: buffer fills, issue stops, head holds.
    out_ready = 1'b0;
    tick();
    check_stream("stall1", 32'h10, 32'h18);
    tick();
    check_stream("stall2", 32'h10, 32'h18);
    tick();
    check_stream("stall3", 32'h10, 32'h18);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_stream("resume", 32'(20 + 4 * k), 32'(28 + 4 * k));
    end

    // Fill the buffer, then redirect to an unaligned target.
    out_ready = 1'b0;
    tick();
    check_stream("refill", 32'h1C, 32'h24);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    check_empty("redir", 32'h0000_0100);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    tick();
    check_empty("redir+1", 32'h0000_0104);
    tick();
    check_stream("redir+2", 32'h0000_0100, 32'h0000_0108);
    tick();
    check_stream("redir+3", 32'h0000_0104, 32'h0000_010C);

    // Redirect with a transfer in the same cycle, target near the top.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    check_empty("wrap.redir", 32'hFFFF_FFF8);
    redirect_valid = 1'b0;
    tick();
    check_empty("wrap.1", 32'hFFFF_FFFC);
    tick();
    check_stream("wrap.2", 32'hFFFF_FFF8, 32'h0000_0000);
    tick();
    check_stream("wrap.3", 32'hFFFF_FFFC, 32'h0000_0004);
    tick();
    check_stream("wrap.4", 32'h0000_0000, 32'h0000_0008);

    // Back-to-back redirects: the last target wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    check_empty("b2b.1", 32'h0000_0200);
    redirect_pc = 32'h0000_0300;
    tick();
    check_empty("b2b.2", 32'h0000_0300);
    redirect_valid = 1'b0;
    tick();
    check_empty("b2b.3", 32'h0000_0304);
    tick();
    check_stream("b2b.4", 32'h0000_0300, 32'h0000_0308);

    // One-cycle reset mid-stream.
    rst = 1'b0;
    tick();
    check_empty("mrst.0", 32'h0000_0000);
    check("mrst.pc",  out_pc, 32'h0);
    check("mrst.pfc", perf_fetch_count,    32'h0);
    check("mrst.prc", perf_redirect_count, 32'h0);
    rst = 1'b1;
    tick();
    check_empty("mrst.1", 32'h0000_0004);
    tick();
    check_stream("mrst.2", 32'h0000_0000, 32'h0000_0008);

    // Perf counters: 10 transfers, then 3 redirect cycles with no transfer.
    for (int k = 1; k <= 10; k++) tick();
    check_stream("perf.run", 32'h0000_0028, 32'h0000_0030);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    for (int k = 0; k < 3; k++) tick();
    redirect_valid = 1'b0;
    check_empty("perf.redir", 32'h0000_0080);
    check("perf.fetch",    perf_fetch_count,    exp_fetch);
    check("perf.redirect", perf_redirect_count, exp_redir);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
